// File: rtl/memory_pkg.sv
// Shared definitions for the ledger memory handshake: responder state
// encodings and the burst geometry both ends of the handshake agree on.
package memory_pkg;

    // Responder states; IDLE must stay at encoding 0.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Words per burst; the controller's wait counters are sized from this.
    localparam int BURST_LEN  = DEF_DEPTH;

endpackage

// File: rtl/ledger_regfile.sv
// Ledger register file: DEPTH x DATA_W words, one write port, one
// registered read port. Every word returns to INIT_VALUE on reset.
module ledger_regfile #(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 8,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int                ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Word storage: reset reloads every word, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        // NOTE: the array is in the reset branch on purpose -- a reset must
        // discard partially written bursts, which rules out a reset-less RAM.
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_VALUE;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; returns zero on cycles with no read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: streams the whole ledger register file out as a
// read burst on load_req and absorbs a same-length write burst while the
// controller holds write_enable.
module memory_responder
    import memory_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                DEPTH      = DEF_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load_req,
    input  logic                     write_enable,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic [$clog2(DEPTH)-1:0] rindex,
    output logic                     wr_done,
    output logic                     ready
);

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_next_ptr;

    logic              r_rvalid;
    logic [ADDR_W-1:0] r_rindex;
    logic              r_wr_done;
    logic              w_next_rvalid;
    logic [ADDR_W-1:0] w_next_rindex;
    logic              w_next_wr_done;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    // State and burst pointer register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of block evaluation order.
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    // Next state, pointer, register-file strobes and next output values.
    // The read strobe fires one cycle ahead of rvalid so the registered
    // read port and the rvalid/rindex registers line up.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        w_next_state   = r_state;
        w_next_ptr     = r_ptr;
        w_wr_en        = 1'b0;
        w_wr_addr      = r_ptr;
        w_rd_en        = 1'b0;
        w_rd_addr      = r_ptr;
        w_next_rvalid  = 1'b0;
        w_next_rindex  = '0;
        w_next_wr_done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (write_enable) begin
                    // Write wins over a simultaneous load_req, which is dropped.
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_next_ptr   = ADDR_W'(1);
                    w_next_state = ST_WRITE;
                end else if (load_req) begin
                    w_rd_en       = 1'b1;
                    w_rd_addr     = '0;
                    w_next_rvalid = 1'b1;
                    w_next_rindex = '0;
                    w_next_ptr    = ADDR_W'(1);
                    w_next_state  = ST_READ;
                end
            end

            ST_READ: begin
                if (r_rindex == LAST_IDX) begin
                    // Last word is on the bus this cycle; pointer has wrapped.
                    w_next_state = ST_IDLE;
                end else begin
                    w_rd_en       = 1'b1;
                    w_next_rvalid = 1'b1;
                    w_next_rindex = r_ptr;
                    w_next_ptr    = r_ptr + ADDR_W'(1);
                end
            end

            ST_WRITE: begin
                if (write_enable) begin
                    w_wr_en    = 1'b1;
                    w_next_ptr = r_ptr + ADDR_W'(1);
                    if (r_ptr == LAST_IDX) begin
                        w_next_wr_done = 1'b1;
                        w_next_state   = ST_IDLE;
                    end
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_next_ptr   = '0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rvalid  <= 1'b0;
            r_rindex  <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_rvalid  <= w_next_rvalid;
            r_rindex  <= w_next_rindex;
            r_wr_done <= w_next_wr_done;
        end
    end

    ledger_regfile #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT_VALUE),
        .ADDR_W     (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .resetn    (resetn),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (wdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign rdata   = w_rd_data;
    assign rvalid  = r_rvalid;
    assign rindex  = r_rindex;
    assign wr_done = r_wr_done;
    assign ready   = (r_state == ST_IDLE);

endmodule
